// File: rtl/localbp_update_queue_pkg.sv
// Shared types for the local-history predictor update path: the core config
// struct that sizes the LHR array and PHT index, and its default instance.
package localbp_update_queue_pkg;

    typedef struct packed {
        int BPRED_NUM_LHR;  // log2 of the number of local history registers
        int BPRED_SIZE;     // local history length, also the PHT index width
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{BPRED_NUM_LHR: 6, BPRED_SIZE: 10};

endpackage

// File: rtl/localbp_upd_match.sv
// Youngest-match search over the pending update entries, walking from the
// slot just behind the tail toward the head so the newest history wins.
module localbp_upd_match #(
    parameter int m     = 6,
    parameter int k     = 10,
    parameter int DEPTH = 4
) (
    input  logic [m-1:0]               lhr_idx_i [DEPTH],
    input  logic [k-1:0]               hist_i    [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   tail_i,
    input  logic [$clog2(DEPTH):0]     count_i,
    input  logic [m-1:0]               query_i,
    output logic                       hit_o,
    output logic [k-1:0]               hist_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] slot;

    // NOTE: every variable written here gets a default first, so no path
    // through the loop leaves one holding its old value (no inferred latch).
    always_comb begin
        hit_o  = 1'b0;
        hist_o = '0;
        slot   = '0;
        for (int j = 0; j < DEPTH; j++) begin
            slot = tail_i - AW'(j + 1);
            if (!hit_o && (j < int'(count_i)) && (lhr_idx_i[slot] == query_i)) begin
                hit_o  = 1'b1;
                hist_o = hist_i[slot];
            end
        end
    end

endmodule

// File: rtl/localbp_update_queue.sv
// In-order queue of resolved branch updates feeding the PHT and LHR write
// ports, with forwarding of the youngest pending history to the F-stage lookup.
module localbp_update_queue
    import localbp_update_queue_pkg::*;
#(
    parameter cvw_t P     = CVW_DEFAULT,
    parameter int   m     = P.BPRED_NUM_LHR,
    parameter int   k     = P.BPRED_SIZE,
    parameter int   DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         StallW,
    input  logic         FlushW,
    input  logic         BranchM,
    input  logic         PCSrcM,
    input  logic [k-1:0] LHRM,
    input  logic [m-1:0] IndexLHRM,
    input  logic [1:0]   NewBPDirPredM,
    input  logic         WrReady,
    input  logic [m-1:0] IndexLHRNextF,
    output logic         PHTWriteEn,
    output logic [k-1:0] PHTWriteAddr,
    output logic [1:0]   PHTWriteData,
    output logic         LHRWriteEn,
    output logic [m-1:0] LHRWriteIndex,
    output logic [k-1:0] LHRWriteData,
    output logic         FwdHitF,
    output logic [k-1:0] FwdLHRF,
    output logic         QueueFull,
    output logic         Dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [k-1:0] pht_addr;
        logic [1:0]   ctr;
        logic [m-1:0] lhr_idx;
        logic [k-1:0] hist;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic          dropped_q, dropped_d;

    logic [PW-1:0] count;
    logic          empty, full, enq_req, enq, deq;
    entry_t        head_entry, new_entry;
    logic [m-1:0]  idx_arr  [DEPTH];
    logic [k-1:0]  hist_arr [DEPTH];
    logic          fwd_hit;
    logic [k-1:0]  fwd_lhr;

    assign count   = tail_q - head_q;
    assign empty   = (count == '0);
    assign full    = (head_q[AW] != tail_q[AW]) && (head_q[AW-1:0] == tail_q[AW-1:0]);
    // A pending reset blocks draining so no write leaks out in the reset cycle.
    assign deq     = ~empty & WrReady & ~reset;
    assign enq_req = BranchM & ~StallW & ~FlushW;
    assign enq     = enq_req & (~full | deq);

    assign head_entry = mem_q[head_q[AW-1:0]];
    assign new_entry  = '{pht_addr: LHRM,
                          ctr:      NewBPDirPredM,
                          lhr_idx:  IndexLHRM,
                          hist:     {PCSrcM, LHRM[k-1:1]}};

    always_comb begin
        head_d    = head_q + PW'(deq);
        tail_d    = tail_q + PW'(enq);
        dropped_d = dropped_q | (enq_req & full & ~deq);
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            dropped_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            dropped_q <= dropped_d;
        end
    end

    // NOTE: entry storage is deliberately not reset; the pointers alone decide
    // which slots are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (enq) mem_q[tail_q[AW-1:0]] <= new_entry;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            idx_arr[i]  = mem_q[i].lhr_idx;
            hist_arr[i] = mem_q[i].hist;
        end
    end

    localbp_upd_match #(.m(m), .k(k), .DEPTH(DEPTH)) u_match (
        .lhr_idx_i (idx_arr),
        .hist_i    (hist_arr),
        .tail_i    (tail_q[AW-1:0]),
        .count_i   (count),
        .query_i   (IndexLHRNextF),
        .hit_o     (fwd_hit),
        .hist_o    (fwd_lhr)
    );

    always_comb begin
        PHTWriteEn    = 1'b0;
        PHTWriteAddr  = '0;
        PHTWriteData  = '0;
        LHRWriteEn    = 1'b0;
        LHRWriteIndex = '0;
        LHRWriteData  = '0;
        if (deq) begin
            PHTWriteEn    = 1'b1;
            PHTWriteAddr  = head_entry.pht_addr;
            PHTWriteData  = head_entry.ctr;
            LHRWriteEn    = 1'b1;
            LHRWriteIndex = head_entry.lhr_idx;
            LHRWriteData  = head_entry.hist;
        end
    end

    assign FwdHitF   = fwd_hit & ~reset;
    assign FwdLHRF   = FwdHitF ? fwd_lhr : '0;
    assign QueueFull = full & ~reset;
    assign Dropped   = dropped_q;

endmodule

// File: tb/tb_localbp_update_queue.sv
// Directed bench for localbp_update_queue: single update, backpressure,
// forwarding, flush/stall gating, full-queue pass-through and reset mid-drain.
module tb_localbp_update_queue;
    import localbp_update_queue_pkg::*;

    logic       clk = 1'b0;
    logic       reset, StallW, FlushW, BranchM, PCSrcM, WrReady;
    logic [9:0] LHRM;
    logic [5:0] IndexLHRM, IndexLHRNextF;
    logic [1:0] NewBPDirPredM;
    logic       PHTWriteEn, LHRWriteEn, FwdHitF, QueueFull, Dropped;
    logic [9:0] PHTWriteAddr, LHRWriteData, FwdLHRF;
    logic [1:0] PHTWriteData;
    logic [5:0] LHRWriteIndex;

    int n_cmp = 0;
    int n_mis = 0;

    logic [9:0] fill_hist [4] = '{10'h080, 10'h280, 10'h081, 10'h281};

    localbp_update_queue #(.P(CVW_DEFAULT), .m(6), .k(10), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW),
        .BranchM(BranchM), .PCSrcM(PCSrcM), .LHRM(LHRM), .IndexLHRM(IndexLHRM),
        .NewBPDirPredM(NewBPDirPredM), .WrReady(WrReady), .IndexLHRNextF(IndexLHRNextF),
        .PHTWriteEn(PHTWriteEn), .PHTWriteAddr(PHTWriteAddr), .PHTWriteData(PHTWriteData),
        .LHRWriteEn(LHRWriteEn), .LHRWriteIndex(LHRWriteIndex), .LHRWriteData(LHRWriteData),
        .FwdHitF(FwdHitF), .FwdLHRF(FwdLHRF), .QueueFull(QueueFull), .Dropped(Dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_write(input string tag, input logic en, input logic [9:0] addr,
                               input logic [1:0] ctr, input logic [5:0] idx, input logic [9:0] hist);
        check({tag, ".pht_en"},   32'(PHTWriteEn),    32'(en));
        check({tag, ".lhr_en"},   32'(LHRWriteEn),    32'(en));
        check({tag, ".pht_addr"}, 32'(PHTWriteAddr),  32'(addr));
        check({tag, ".pht_data"}, 32'(PHTWriteData),  32'(ctr));
        check({tag, ".lhr_idx"},  32'(LHRWriteIndex), 32'(idx));
        check({tag, ".lhr_data"}, 32'(LHRWriteData),  32'(hist));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_br(input logic taken, input logic [9:0] lhr,
                            input logic [5:0] idx, input logic [1:0] ctr);
        BranchM       = 1'b1;
        PCSrcM        = taken;
        LHRM          = lhr;
        IndexLHRM     = idx;
        NewBPDirPredM = ctr;
    endtask

    initial begin
        reset = 1'b1; StallW = 1'b0; FlushW = 1'b0; BranchM = 1'b0; PCSrcM = 1'b0;
        WrReady = 1'b0; LHRM = '0; IndexLHRM = '0; NewBPDirPredM = '0; IndexLHRNextF = '0;
        tick();
        tick();
        reset = 1'b0;
        settle();
        check_write("reset", 1'b0, 10'h0, 2'd0, 6'd0, 10'h0);
        check("reset.full",    32'(QueueFull), 32'd0);
        check("reset.dropped", 32'(Dropped),   32'd0);
        check("reset.fwd_hit", 32'(FwdHitF),   32'd0);
        check("reset.fwd_lhr", 32'(FwdLHRF),   32'd0);

        // Single update: visible the cycle after the enqueue edge, not before.
        WrReady = 1'b1;
        drive_br(1'b1, 10'h0F0, 6'd5, 2'b11);
        settle();
        check("single.no_bypass", 32'(PHTWriteEn), 32'd0);
        tick();
        BranchM = 1'b0;
        settle();
        check_write("single", 1'b1, 10'h0F0, 2'd3, 6'd5, 10'h278);
        tick();
        settle();
        check_write("single.idle", 1'b0, 10'h0, 2'd0, 6'd0, 10'h0);

        // Fill with the write ports busy, overflow once, then drain in order.
        WrReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_br(1'(i & 1), 10'(32'h100 + i), 6'(20 + i), 2'(i));
            tick();
        end
        BranchM = 1'b0;
        settle();
        check("fill.full",    32'(QueueFull),  32'd1);
        check("fill.dropped", 32'(Dropped),    32'd0);
        check("fill.no_wr",   32'(PHTWriteEn), 32'd0);
        drive_br(1'b1, 10'h3FF, 6'd63, 2'b00);
        tick();
        BranchM = 1'b0;
        settle();
        check("overflow.dropped", 32'(Dropped),   32'd1);
        check("overflow.full",    32'(QueueFull), 32'd1);
        WrReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_write($sformatf("drain%0d", i), 1'b1, 10'(32'h100 + i), 2'(i), 6'(20 + i), fill_hist[i]);
            tick();
        end
        settle();
        check("drain.empty",  32'(PHTWriteEn), 32'd0);
        check("drain.full",   32'(QueueFull),  32'd0);
        check("drain.sticky", 32'(Dropped),    32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check("reset2.dropped", 32'(Dropped), 32'd0);

        // Forwarding: youngest match wins, same-cycle enqueue invisible.
        WrReady = 1'b0;
        IndexLHRNextF = 6'd7;
        drive_br(1'b0, 10'h002, 6'd7, 2'd1);
        settle();
        check("fwd.same_cycle", 32'(FwdHitF), 32'd0);
        tick();
        drive_br(1'b1, 10'h001, 6'd7, 2'd2);
        settle();
        check("fwd.one.hit", 32'(FwdHitF), 32'd1);
        check("fwd.one.lhr", 32'(FwdLHRF), 32'h001);
        tick();
        BranchM = 1'b0;
        settle();
        check("fwd.two.hit", 32'(FwdHitF), 32'd1);
        check("fwd.two.lhr", 32'(FwdLHRF), 32'h200);
        IndexLHRNextF = 6'd8;
        settle();
        check("fwd.miss.hit", 32'(FwdHitF), 32'd0);
        check("fwd.miss.lhr", 32'(FwdLHRF), 32'd0);
        IndexLHRNextF = 6'd7;
        WrReady = 1'b1;
        settle();
        check("fwd.drain0.data", 32'(LHRWriteData), 32'h001);
        check("fwd.drain0.lhr",  32'(FwdLHRF),      32'h200);
        tick();
        settle();
        check("fwd.drain1.data", 32'(LHRWriteData), 32'h200);
        check("fwd.head.hit",    32'(FwdHitF),      32'd1);
        check("fwd.head.lhr",    32'(FwdLHRF),      32'h200);
        tick();
        settle();
        check("fwd.empty.hit", 32'(FwdHitF),    32'd0);
        check("fwd.empty.wr",  32'(PHTWriteEn), 32'd0);

        // Forwarding across the storage wrap point with interleaved indices.
        WrReady = 1'b0;
        drive_br(1'b0, 10'h3FE, 6'd9, 2'd0); tick();
        drive_br(1'b1, 10'h0AA, 6'd7, 2'd0); tick();
        drive_br(1'b1, 10'h000, 6'd9, 2'd0); tick();
        BranchM = 1'b0;
        IndexLHRNextF = 6'd7;
        settle();
        check("wrap.idx7.lhr", 32'(FwdLHRF), 32'h255);
        IndexLHRNextF = 6'd9;
        settle();
        check("wrap.idx9.lhr", 32'(FwdLHRF), 32'h200);
        WrReady = 1'b1;
        tick(); tick(); tick();
        settle();
        check("wrap.drained", 32'(PHTWriteEn), 32'd0);

        // Flush and stall each suppress the enqueue.
        drive_br(1'b1, 10'h155, 6'd3, 2'd1);
        FlushW = 1'b1;
        tick();
        FlushW = 1'b0;
        StallW = 1'b1;
        settle();
        check("flush.no_wr", 32'(PHTWriteEn), 32'd0);
        tick();
        StallW = 1'b0;
        BranchM = 1'b0;
        settle();
        check("stall.no_wr", 32'(PHTWriteEn), 32'd0);
        check("stall.no_fwd", 32'(FwdHitF),   32'd0);

        // Full queue with simultaneous enqueue and dequeue.
        WrReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_br(1'b0, 10'(32'h010 + i), 6'(30 + i), 2'd1);
            tick();
        end
        drive_br(1'b1, 10'h3C0, 6'd40, 2'd2);
        WrReady = 1'b1;
        settle();
        check("pass.full",  32'(QueueFull),    32'd1);
        check("pass.addr0", 32'(PHTWriteAddr), 32'h010);
        tick();
        BranchM = 1'b0;
        settle();
        check("pass.still_full", 32'(QueueFull),    32'd1);
        check("pass.dropped",    32'(Dropped),      32'd0);
        check("pass.addr1",      32'(PHTWriteAddr), 32'h011);
        tick();
        settle();
        check("pass.not_full", 32'(QueueFull),    32'd0);
        check("pass.addr2",    32'(PHTWriteAddr), 32'h012);
        tick();
        settle();
        check("pass.addr3", 32'(PHTWriteAddr), 32'h013);
        tick();
        settle();
        check_write("pass.new", 1'b1, 10'h3C0, 2'd2, 6'd40, 10'h3E0);
        tick();
        settle();
        check("pass.empty", 32'(PHTWriteEn), 32'd0);

        // Reset with three entries pending discards them all.
        WrReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_br(1'b1, 10'(32'h2A0 + i), 6'(50 + i), 2'd3);
            tick();
        end
        BranchM = 1'b0;
        IndexLHRNextF = 6'd50;
        WrReady = 1'b1;
        reset = 1'b1;
        settle();
        check("rst_mid.cycle.pht_en", 32'(PHTWriteEn), 32'd0);
        check("rst_mid.cycle.lhr_en", 32'(LHRWriteEn), 32'd0);
        tick();
        reset = 1'b0;
        settle();
        check("rst_mid.after.pht_en", 32'(PHTWriteEn), 32'd0);
        check("rst_mid.after.full",   32'(QueueFull),  32'd0);
        check("rst_mid.after.fwd",    32'(FwdHitF),    32'd0);
        tick();
        settle();
        check("rst_mid.later.pht_en", 32'(PHTWriteEn), 32'd0);
        check("rst_mid.later.lhr_en", 32'(LHRWriteEn), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
